iic_eeprom_slave: RTL and testbench

- I2C target (responder) that sits on the same two-wire bus driven by iic_ctrl and emulates a 24Cxx-style EEPROM for on-chip verification and loopback.
- Oversamples SCL/SDA with the system clock, detects START/STOP and matches a 7-bit device address.
- Write transfers take a word-pointer byte followed by data bytes. Read transfers return data at the pointer.
- Storage is external, reached through a simple synchronous memory port. The pointer auto-increments.

---
 rtl/iic_pkg.sv | 22 ++
 rtl/iic_bus_sync.sv | 44 ++++
 rtl/iic_eeprom_slave.sv | 181 ++++++++++++++++++
 tb/tb_iic_eeprom_slave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared I2C constants and target state encoding
package iic_pkg;

    localparam int   BYTE_W = 8;
    localparam int   RW_BIT = 0;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEVADR,
        ST_ACK_DEV,
        ST_PTR,
        ST_ACK_PTR,
        ST_WDATA,
        ST_ACK_WR,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } iic_state_e;

endpackage

// File: rtl/iic_bus_sync.sv
// rtl/iic_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP pulse generation
module iic_bus_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STG-1:0] scl_sh;
    logic [SYNC_STG-1:0] sda_sh;
    logic                scl;
    logic                scl_d;
    logic                sda_d;

    // Chains reset to the idle-bus level so reset does not fabricate a START
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sh <= '1;
            sda_sh <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sh <= {scl_sh[SYNC_STG-2:0], scl_i};
            sda_sh <= {sda_sh[SYNC_STG-2:0], sda_i};
            scl_d  <= scl;
            sda_d  <= sda;
        end
    end

    assign scl      = scl_sh[SYNC_STG-1];
    assign sda      = sda_sh[SYNC_STG-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/iic_eeprom_slave.sv
// rtl/iic_eeprom_slave.sv - I2C target emulating a 24Cxx EEPROM over a synchronous memory port
module iic_eeprom_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h63,
    parameter int         ADDR_W   = 8,
    parameter int         SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    iic_bus_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    iic_state_e        state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [7:0]        wdata_nxt;
    logic              rw, rw_nxt;
    logic              sda_oe_nxt, busy_nxt, we_nxt, re_nxt;
    logic              rd_pend;
    logic              shift_in, byte_done;

    assign shift_in  = scl_rise && (bit_cnt != 4'd8);
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign mem_addr  = ptr;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        wdata_nxt   = mem_wdata;
        rw_nxt      = rw;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;

        // Read data lands one clk after the strobe; writes bump the pointer one clk after mem_we
        if (rd_pend) shreg_nxt = mem_rdata;
        if (mem_we)  ptr_nxt   = ptr + 1'b1;

        if (stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start) begin
            state_nxt   = ST_DEVADR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ST_DEVADR, ST_PTR, ST_WDATA: begin
                    if (shift_in) begin
                        shreg_nxt   = {shreg[BYTE_W-2:0], sda};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end else if (byte_done) begin
                        bit_cnt_nxt = 4'd0;
                        sda_oe_nxt  = 1'b1;
                        if (state == ST_DEVADR) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                busy_nxt  = 1'b1;
                                rw_nxt    = shreg[RW_BIT];
                                re_nxt    = shreg[RW_BIT];
                                state_nxt = ST_ACK_DEV;
                            end else begin
                                sda_oe_nxt = 1'b0;
                                state_nxt  = ST_WAIT;
                            end
                        end else if (state == ST_PTR) begin
                            ptr_nxt   = ADDR_W'(shreg);
                            state_nxt = ST_ACK_PTR;
                        end else begin
                            wdata_nxt = shreg;
                            we_nxt    = 1'b1;
                            state_nxt = ST_ACK_WR;
                        end
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw) begin
                            sda_oe_nxt  = ~shreg[7];
                            shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
                            bit_cnt_nxt = 4'd1;
                            state_nxt   = ST_RDATA;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                            state_nxt   = ST_PTR;
                        end
                    end
                end
                ST_ACK_PTR, ST_ACK_WR: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (byte_done) begin
                        sda_oe_nxt = 1'b0;
                        ptr_nxt    = ptr + 1'b1;
                        state_nxt  = ST_RACK;
                    end else if (scl_fall) begin
                        sda_oe_nxt  = ~shreg[7];
                        shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                ST_RACK: begin
                    // A NACK leaves on the rise, so any fall seen here follows a master ACK
                    if (scl_rise) begin
                        if (sda == ACK) re_nxt    = 1'b1;
                        else            state_nxt = ST_WAIT;
                    end else if (scl_fall) begin
                        sda_oe_nxt  = ~shreg[7];
                        shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
                        bit_cnt_nxt = 4'd1;
                        state_nxt   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            ptr       <= '0;
            mem_wdata <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            ptr       <= ptr_nxt;
            mem_wdata <= wdata_nxt;
            rw        <= rw_nxt;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            mem_we    <= we_nxt;
            mem_re    <= re_nxt;
            rd_pend   <= mem_re;
        end
    end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// tb/tb_iic_eeprom_slave.sv - self-checking bench for iic_eeprom_slave with an I2C master model and EEPROM reference
module tb_iic_eeprom_slave;

    localparam int Q = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe, mem_we, mem_re, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr;
    logic [7:0] we_addr_log [256];
    logic [7:0] we_data_log [256];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0, re_cnt = 0, oe_cnt = 0, busy_cnt = 0, clash_cnt = 0;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    iic_eeprom_slave #(.DEV_ADDR(7'h63), .ADDR_W(8), .SYNC_STG(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr]            <= mem_wdata;
            we_addr_log[we_cnt[7:0]]    <= mem_addr;
            we_data_log[we_cnt[7:0]]    <= mem_wdata;
            we_cnt                      <= we_cnt + 1;
        end else if (bd_we) begin
            tb_mem[bd_addr] <= bd_data;
        end
        if (mem_re) begin
            mem_rdata <= tb_mem[mem_addr];
            re_cnt    <= re_cnt + 1;
        end
        if (sda_oe)           oe_cnt    <= oe_cnt + 1;
        if (busy)             busy_cnt  <= busy_cnt + 1;
        if (mem_we && mem_re) clash_cnt <= clash_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick(1);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; tick(Q);
        scl_m = 1'b1; tick(H);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(H / 2);
        b = sda_i; tick(H / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        rst = 1'b1; tick(4);
        checks++; if (sda_oe !== 1'b0)     begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_re !== 1'b0)     begin errors++; $display("FAIL reset_mem_re: got %b want 0", mem_re); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== 8'h00)  begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        rst = 1'b0; tick(4);
        ref_ptr = 8'h00;
    endtask

    task automatic test_write;
        logic a0, a1, a2;
        int   we0;
        we0 = we_cnt;
        bus_start;
        put_byte(8'hC6, a0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
        put_byte(8'h10, a1);
        put_byte(8'hA5, a2);
        bus_stop;
        ref_mem[8'h10] = 8'hA5; ref_ptr = 8'h11;
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
        checks++; if (we_addr_log[we0[7:0]] !== 8'h10) begin errors++; $display("FAIL write_addr: got %h want 10", we_addr_log[we0[7:0]]); end
        checks++; if (we_data_log[we0[7:0]] !== 8'hA5) begin errors++; $display("FAIL write_data: got %h want a5", we_data_log[we0[7:0]]); end
        checks++; if (mem_addr !== ref_ptr) begin errors++; $display("FAIL write_ptr: got %h want %h", mem_addr, ref_ptr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_mismatch;
        logic a0, a1;
        int   we0, re0, oe0, bz0;
        we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt; bz0 = busy_cnt;
        bus_start;
        put_byte(8'hC8, a0);
        put_byte(8'h55, a1);
        bus_stop;
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mismatch_nack: got %b want 11", {a0, a1}); end
        checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL mismatch_sda_oe: got %0d cycles want 0", oe_cnt - oe0); end
        checks++; if (we_cnt != we0 || re_cnt != re0) begin errors++; $display("FAIL mismatch_mem: got we=%0d re=%0d want 0 0", we_cnt - we0, re_cnt - re0); end
        checks++; if (busy_cnt != bz0) begin errors++; $display("FAIL mismatch_busy: got %0d cycles want 0", busy_cnt - bz0); end
    endtask

    task automatic random_read(input logic [7:0] p, input int n, input string tag);
        logic       a0, a1, a2, ack_all;
        logic [7:0] d;
        int         re0;
        re0 = re_cnt;
        bus_start;
        put_byte(8'hC6, a0);
        put_byte(p, a1);
        bus_start;
        put_byte(8'hC7, a2);
        ack_all = a0 | a1 | a2;
        checks++; if (ack_all !== 1'b0) begin errors++; $display("FAIL %s_acks: got %b%b%b want 000", tag, a0, a1, a2); end
        ref_ptr = p;
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, d);
            checks++; if (d !== ref_mem[ref_ptr]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, d, ref_mem[ref_ptr]); end
            ref_ptr = ref_ptr + 8'd1;
        end
        bus_stop;
        checks++; if (re_cnt - re0 != n) begin errors++; $display("FAIL %s_re_count: got %0d want %0d", tag, re_cnt - re0, n); end
        checks++; if (mem_addr !== ref_ptr) begin errors++; $display("FAIL %s_ptr: got %h want %h", tag, mem_addr, ref_ptr); end
    endtask

    task automatic test_random_read;
        poke(8'h20, 8'h3C);
        poke(8'h21, 8'h81);
        random_read(8'h20, 2, "rdread");
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        int   we0;
        we0 = we_cnt;
        bus_start;
        put_byte(8'hC6, a0); put_byte(8'hFF, a1);
        put_byte(8'h11, a2); put_byte(8'h22, a3);
        bus_stop;
        ref_mem[8'hFF] = 8'h11; ref_mem[8'h00] = 8'h22; ref_ptr = 8'h01;
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
        checks++; if (we_cnt - we0 != 2) begin errors++; $display("FAIL wrap_we_count: got %0d want 2", we_cnt - we0); end
        checks++; if (we_addr_log[we0[7:0]] !== 8'hFF) begin errors++; $display("FAIL wrap_addr0: got %h want ff", we_addr_log[we0[7:0]]); end
        checks++; if (we_addr_log[8'(we0 + 1)] !== 8'h00) begin errors++; $display("FAIL wrap_addr1: got %h want 00", we_addr_log[8'(we0 + 1)]); end
        checks++; if (mem_addr !== ref_ptr) begin errors++; $display("FAIL wrap_ptr: got %h want %h", mem_addr, ref_ptr); end
    endtask

    task automatic test_abort;
        logic a0, a1, a2, a3, a4;
        int   we0;
        we0 = we_cnt;
        bus_start;
        put_byte(8'hC6, a0); put_byte(8'h40, a1);
        for (int i = 0; i < 4; i++) put_bit(1'($urandom));
        bus_stop;
        ref_ptr = 8'h40;
        checks++; if (we_cnt != we0) begin errors++; $display("FAIL abort_no_we: got %0d want 0", we_cnt - we0); end
        checks++; if (busy !== 1'b0 || mem_addr !== ref_ptr) begin errors++; $display("FAIL abort_idle: got busy=%b ptr=%h want 0 %h", busy, mem_addr, ref_ptr); end
        bus_start;
        put_byte(8'hC6, a2); put_byte(8'h50, a3); put_byte(8'h77, a4);
        bus_stop;
        ref_mem[8'h50] = 8'h77; ref_ptr = 8'h51;
        checks++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin errors++; $display("FAIL abort_acks: got %b want 00000", {a0, a1, a2, a3, a4}); end
        checks++; if (we_cnt - we0 != 1 || we_addr_log[we0[7:0]] !== 8'h50 || we_data_log[we0[7:0]] !== 8'h77) begin
            errors++; $display("FAIL abort_rewrite: got n=%0d %h/%h want 1 50/77", we_cnt - we0, we_addr_log[we0[7:0]], we_data_log[we0[7:0]]);
        end
    endtask

    task automatic test_reset_mid_ack;
        logic [7:0] dev;
        logic       a0;
        int         we0, re0, oe0;
        dev = 8'hC6;
        bus_start;
        for (int i = 7; i >= 0; i--) put_bit(dev[i]);
        sda_m = 1'b1; tick(Q);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstack_ack_driven: got %b want 1", sda_oe); end
        rst = 1'b1; tick(1);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstack_release: got %b want 0", sda_oe); end
        rst = 1'b0;
        ref_ptr = 8'h00;
        we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
        scl_m = 1'b1; tick(H); scl_m = 1'b0; tick(Q);
        for (int i = 0; i < 18; i++) put_bit(1'($urandom));
        checks++; if (oe_cnt != oe0 || we_cnt != we0 || re_cnt != re0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstack_ignored: got oe=%0d we=%0d re=%0d busy=%b want 0 0 0 0", oe_cnt - oe0, we_cnt - we0, re_cnt - re0, busy);
        end
        bus_start;
        put_byte(8'hC6, a0);
        bus_stop;
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL rstack_new_ack: got %b want 0", a0); end
        checks++; if (mem_addr !== ref_ptr) begin errors++; $display("FAIL rstack_ptr: got %h want %h", mem_addr, ref_ptr); end
    endtask

    task automatic test_random;
        logic [7:0] p, d;
        logic       a;
        int         n, we0, bad_ack, bad_log;
        for (int it = 0; it < 4; it++) begin
            p = 8'($urandom); n = $urandom_range(1, 4);
            we0 = we_cnt; bad_ack = 0; bad_log = 0;
            bus_start;
            put_byte(8'hC6, a); bad_ack += int'(a);
            put_byte(p, a);     bad_ack += int'(a);
            ref_ptr = p;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                put_byte(d, a); bad_ack += int'(a);
                ref_mem[ref_ptr] = d;
                if (we_addr_log[8'(we0 + i)] !== ref_ptr || we_data_log[8'(we0 + i)] !== d) bad_log++;
                ref_ptr = ref_ptr + 8'd1;
            end
            bus_stop;
            checks++; if (bad_ack != 0 || bad_log != 0 || we_cnt - we0 != n) begin
                errors++; $display("FAIL rand_write%0d: got nacks=%0d badlog=%0d we=%0d want 0 0 %0d", it, bad_ack, bad_log, we_cnt - we0, n);
            end
            random_read(p - 8'($urandom_range(0, 1)), n + 1, "rand_read");
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_mismatch;
        test_random_read;
        test_wrap;
        test_abort;
        test_reset_mid_ack;
        test_random;
        checks++; if (clash_cnt != 0) begin errors++; $display("FAIL we_re_clash: got %0d cycles want 0", clash_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
